// File: rtl/switch_debounce.sv
// switch_debounce: two-flop synchronizer plus an independent debounce counter per DIP-switch bit.
// Define SWITCH_DEBOUNCE_EDGE_EN to enable the registered per-bit sw_rise/sw_fall strobes.
module switch_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            sync1;
  logic [WIDTH-1:0]            sync2;
  logic [WIDTH-1:0][CNT_W-1:0] cnt;
  logic [WIDTH-1:0]            commit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // NOTE: always_comb outputs get a default first so no latch can be inferred.
  always_comb begin
    commit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      commit[i] = (sync2[i] != sw_stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // NOTE: counters are reset with the outputs so a reset during a pending change discards it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      sw_stable  <= '0;
      sw_changed <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == sw_stable[i]) begin
          cnt[i] <= '0;
        end else if (commit[i]) begin
          cnt[i]       <= '0;
          sw_stable[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      sw_changed <= |commit;
    end
  end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  // A committing bit takes the sync2 value, so sync2 gives the direction of the move.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      sw_rise <= commit & sync2;
      sw_fall <= commit & ~sync2;
    end
  end
`else
  assign sw_rise = '0;
  assign sw_fall = '0;
`endif

endmodule
